// File: rtl/det_3x3_seq_pkg.sv
// Shared definitions for the sequential 3x3 determinant blocks: default width,
// controller state encoding and the step indices of the product schedule.
package det_3x3_seq_pkg;

    localparam int DET_DATA_W = 8;
    localparam int DET_STEP_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] STEP_EI  = 4'd0;
    localparam logic [3:0] STEP_FH  = 4'd1;
    localparam logic [3:0] STEP_DI  = 4'd2;
    localparam logic [3:0] STEP_FG  = 4'd3;
    localparam logic [3:0] STEP_DH  = 4'd4;
    localparam logic [3:0] STEP_EG  = 4'd5;
    localparam logic [3:0] STEP_AM1 = 4'd6;
    localparam logic [3:0] STEP_BM2 = 4'd7;
    localparam logic [3:0] STEP_CM3 = 4'd8;

    function automatic logic is_last_step(input logic [3:0] step);
        return step == STEP_CM3;
    endfunction

endpackage

// File: rtl/det_3x3_seq_mod_mult.sv
// Combinational DATA_W x DATA_W multiplier returning the product modulo
// 2^DATA_W and a flag raised when the true product does not fit.
module mod_mult
    import det_3x3_seq_pkg::*;
#(
    parameter int DATA_W = DET_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_prod,
    output logic              o_flag_overflow
);

    logic [2*DATA_W-1:0] w_full;

    assign w_full          = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign o_prod          = w_full[DATA_W-1:0];
    assign o_flag_overflow = |w_full[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/det_3x3_seq.sv
// Sequential 3x3 determinant: one shared multiplier, nine products per job,
// cofactor expansion along the first row, all arithmetic modulo 2^DATA_W.
module det_3x3_seq
    import det_3x3_seq_pkg::*;
#(
    parameter int DATA_W = DET_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] h,
    input  logic [DATA_W-1:0] i,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] resultado,
    output logic              flag_overflow,
    output logic [1:0]        o_dbg_state,
    output logic [3:0]        o_dbg_step
);

    // Handshake: start is accepted only on an edge where busy is low; the
    // matrix is captured on that edge. done pulses one cycle with resultado
    // valid; starts seen while busy are dropped, never queued.

    logic [1:0]        r_state;
    logic [3:0]        r_step;
    logic [DATA_W-1:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h, r_i;
    logic [DATA_W-1:0] r_m1, r_m2, r_m3;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic              r_ovf;

    logic [DATA_W-1:0] w_op_x;
    logic [DATA_W-1:0] w_op_y;
    logic [DATA_W-1:0] w_prod;
    logic              w_prod_ovf;

    always_comb begin
        w_op_x = '0;
        w_op_y = '0;
        case (r_step)
            STEP_EI:  begin w_op_x = r_e; w_op_y = r_i;  end
            STEP_FH:  begin w_op_x = r_f; w_op_y = r_h;  end
            STEP_DI:  begin w_op_x = r_d; w_op_y = r_i;  end
            STEP_FG:  begin w_op_x = r_f; w_op_y = r_g;  end
            STEP_DH:  begin w_op_x = r_d; w_op_y = r_h;  end
            STEP_EG:  begin w_op_x = r_e; w_op_y = r_g;  end
            STEP_AM1: begin w_op_x = r_a; w_op_y = r_m1; end
            STEP_BM2: begin w_op_x = r_b; w_op_y = r_m2; end
            STEP_CM3: begin w_op_x = r_c; w_op_y = r_m3; end
            default:  begin w_op_x = '0;  w_op_y = '0;   end
        endcase
    end

    mod_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .i_a             (w_op_x),
        .i_b             (w_op_y),
        .o_prod          (w_prod),
        .o_flag_overflow (w_prod_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_step   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_e      <= '0;
            r_f      <= '0;
            r_g      <= '0;
            r_h      <= '0;
            r_i      <= '0;
            r_m1     <= '0;
            r_m2     <= '0;
            r_m3     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_c     <= c;
                        r_d     <= d;
                        r_e     <= e;
                        r_f     <= f;
                        r_g     <= g;
                        r_h     <= h;
                        r_i     <= i;
                        r_ovf   <= 1'b0;
                        r_step  <= STEP_EI;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_ovf <= r_ovf | w_prod_ovf;
                    // Minors are built in place: first product loads, second subtracts.
                    case (r_step)
                        STEP_EI:  r_m1  <= w_prod;
                        STEP_FH:  r_m1  <= r_m1 - w_prod;
                        STEP_DI:  r_m2  <= w_prod;
                        STEP_FG:  r_m2  <= r_m2 - w_prod;
                        STEP_DH:  r_m3  <= w_prod;
                        STEP_EG:  r_m3  <= r_m3 - w_prod;
                        STEP_AM1: r_acc <= w_prod;
                        STEP_BM2: r_acc <= r_acc - w_prod;
                        STEP_CM3: begin
                            r_acc    <= r_acc + w_prod;
                            r_result <= r_acc + w_prod;
                        end
                        default:  r_acc <= r_acc;
                    endcase
                    if (is_last_step(r_step)) begin
                        r_step  <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_step <= r_step + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_step  <= '0;
                end
            endcase
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign resultado     = r_result;
    assign flag_overflow = r_ovf;
    assign o_dbg_state   = r_state;
    assign o_dbg_step    = r_step;

endmodule

// File: tb/tb_det_3x3_seq.sv
// Directed bench for det_3x3_seq: hand-computed determinants, latency,
// ignored starts, back-to-back jobs and reset abort.
module tb_det_3x3_seq;
    import det_3x3_seq_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b, c, d, e, f, g, h, i;
    logic         busy;
    logic         done;
    logic [W-1:0] resultado;
    logic         flag_overflow;
    logic [1:0]   dbg_state;
    logic [3:0]   dbg_step;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    det_3x3_seq #(
        .DATA_W (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .c             (c),
        .d             (d),
        .e             (e),
        .f             (f),
        .g             (g),
        .h             (h),
        .i             (i),
        .busy          (busy),
        .done          (done),
        .resultado     (resultado),
        .flag_overflow (flag_overflow),
        .o_dbg_state   (dbg_state),
        .o_dbg_step    (dbg_step)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_mat(input logic [W-1:0] v0, input logic [W-1:0] v1, input logic [W-1:0] v2,
                           input logic [W-1:0] v3, input logic [W-1:0] v4, input logic [W-1:0] v5,
                           input logic [W-1:0] v6, input logic [W-1:0] v7, input logic [W-1:0] v8);
        a = v0; b = v1; c = v2;
        d = v3; e = v4; f = v5;
        g = v6; h = v7; i = v8;
    endtask

    // Pulse start, expect done after the 9th edge, then idle after the 10th.
    task automatic run_job(input string tag, input logic [W-1:0] exp_res, input logic exp_ovf);
        int lat;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        check({tag, "_resultado"}, 32'(resultado), 32'(exp_res));
        check({tag, "_flag_overflow"}, 32'(flag_overflow), 32'(exp_ovf));
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_dropped"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int second_done;
        logic [W-1:0] res_a;
        logic [W-1:0] res_b;

        rst_n = 1'b0;
        start = 1'b0;
        set_mat(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_resultado", 32'(resultado), 32'd0);
        check("reset_flag", 32'(flag_overflow), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        check("reset_step", 32'(dbg_step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        set_mat(1, 0, 0, 0, 1, 0, 0, 0, 1);
        run_job("identity", 8'd1, 1'b0);

        set_mat(2, 0, 0, 0, 3, 0, 0, 0, 4);
        run_job("diag_234", 8'd24, 1'b0);

        set_mat(1, 2, 3, 4, 5, 6, 7, 8, 9);
        run_job("seq_1to9", 8'd0, 1'b1);

        set_mat(16, 0, 0, 0, 16, 0, 0, 0, 1);
        run_job("diag_16_wrap", 8'd0, 1'b1);

        // det = -1 wraps to 255, no product overflows
        set_mat(0, 1, 0, 1, 0, 0, 0, 0, 1);
        run_job("neg_wrap", 8'd255, 1'b0);

        // Starts during CALC (cycle 3) and DONE (cycle 9) with new inputs are dropped
        set_mat(2, 0, 0, 0, 3, 0, 0, 0, 4);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        first_done = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            if (k == 3 || k == 9) begin
                start = 1'b1;
                set_mat(7, 7, 7, 7, 7, 7, 7, 7, 7);
            end else begin
                start = 1'b0;
            end
        end
        check("ignore_done_count", 32'(done_cnt), 32'd1);
        check("ignore_latency", 32'(first_done), 32'd9);
        check("ignore_resultado", 32'(resultado), 32'd24);
        check("ignore_idle_after", 32'(busy), 32'd0);

        // Start held high: one job every 11 cycles
        set_mat(2, 0, 0, 0, 3, 0, 0, 0, 4);
        @(negedge clk);
        start = 1'b1;
        first_done = 0;
        second_done = 0;
        res_a = '0;
        res_b = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_done == 0) begin
                    first_done = k;
                    res_a = resultado;
                    set_mat(0, 1, 0, 1, 0, 0, 0, 0, 1);
                end else begin
                    second_done = k;
                    res_b = resultado;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_interval", 32'(second_done - first_done), 32'd11);
        check("held_first_res", 32'(res_a), 32'd24);
        check("held_second_res", 32'(res_b), 32'd255);
        @(posedge clk);
        #1;
        check("held_idle_after", 32'(busy), 32'd0);

        // Reset abort at step 5
        set_mat(1, 2, 3, 4, 5, 6, 7, 8, 9);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_at_step5", 32'(dbg_step), 32'd5);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_resultado", 32'(resultado), 32'd0);
        check("abort_flag", 32'(flag_overflow), 32'd0);
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        // det = 2*(12-1) - 1*(4-0) + 0 = 18
        set_mat(2, 1, 0, 1, 3, 1, 0, 1, 4);
        run_job("post_reset", 8'd18, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/det_3x3_seq.md
DET_3X3_SEQ -- requirements
Module: det_3x3_seq

Interface
REQ-001 Parameter: DATA_W, default 8, element/result width; all arithmetic modulo 2^DATA_W.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a determinant; sampled only in IDLE.
REQ-006 a,b,c,d,e,f,g,h,i  input  DATA_W each  row-major 3x3 elements; sampled on the accepting edge only.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; resultado valid.
REQ-009 resultado  output  DATA_W  determinant mod 2^DATA_W; held until next accepted start.
REQ-010 flag_overflow  output  1  sticky OR of every product overflow (true product >= 2^DATA_W) in the current job.

Function
REQ-011 States SHALL be IDLE, CALC, DONE; CALC SHALL carry a 4-bit step counter 0..8.
REQ-012 IDLE with start=1 at an edge SHALL latch all nine elements, clear flag_overflow, set step=0, and enter CALC.
REQ-013 A single shared DATA_W x DATA_W multiplier SHALL perform exactly one product per CALC cycle, in this order: e*i, f*h, d*i, f*g, d*h, e*g, a*m1, b*m2, c*m3.
REQ-014 m1=(e*i - f*h), m2=(d*i - f*g), m3=(d*h - e*g), each truncated to DATA_W bits and stored in registers.
REQ-015 Accumulator: step 6 acc=p; step 7 acc=acc-p; step 8 acc=acc+p; all wrap mod 2^DATA_W.
REQ-016 After step 8, state SHALL be DONE, resultado=acc, and done=1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-017 Latency: if the accepting edge is t0, done SHALL be high in the cycle following edge t9 (9 cycles), and busy SHALL drop after edge t10.
REQ-018 start while in CALC or DONE SHALL be ignored (no queuing); input changes during CALC SHALL have no effect.
REQ-019 start held high continuously SHALL start a new job at each IDLE visit, giving one job every 11 cycles.
REQ-020 Overflow SHALL be evaluated on the truncated stored operands (m1..m3), not on the true integer minors.
REQ-021 resultado and flag_overflow SHALL change only on an accepting edge (flag clear) or during CALC/DONE (update); they SHALL be stable in IDLE.

Reset
REQ-022 rst_n low SHALL asynchronously force: state=IDLE, step=0, busy=0, done=0, resultado=0, flag_overflow=0, and zero all minors, accumulator and latched operands.
REQ-023 Reset asserted during CALC or DONE SHALL abort the job with no done pulse; the first start after release SHALL begin a fresh job.

Structure
REQ-024 State encoding, step indices 0..8, and DATA_W default SHALL reside in a shared package for the determinant blocks.
REQ-025 The single shared multiplier SHALL be the existing mod_mult sub-module, with its flag_overflow feeding REQ-010; no other arithmetic sub-module.
REQ-026 Operand selection SHALL be a step-indexed mux; the block SHALL contain no second multiplier.

Verification
REQ-027 Identity matrix (1,0,0,0,1,0,0,0,1), start pulse -> done 9 cycles later, resultado=1, flag_overflow=0.
REQ-028 Diagonal (2,0,0,0,3,0,0,0,4) -> resultado=24, flag_overflow=0.
REQ-029 (1,2,3,4,5,6,7,8,9) -> resultado=0, flag_overflow=1 (b*m2 = 2*250).
REQ-030 Diagonal (16,0,0,0,16,0,0,0,1) -> resultado=0 (256 wraps), flag_overflow=1.
REQ-031 start re-pulsed at cycles 3 and 9 of a job, with inputs changed -> ignored; exactly one done, first-job result unchanged.
REQ-032 rst_n low at step 5 -> busy=0, done never pulses, outputs 0; a new start then yields the correct result with nominal latency.
